// File: rtl/riscv_memory_stage_pkg.sv
// Shared encodings for the memory stage: result-source select, load/store
// size codes and the data-memory FSM states.
package riscv_memory_stage_pkg;

    // Result source select carried down to writeback
    localparam logic [1:0] ResultSrcAlu = 2'b00;
    localparam logic [1:0] ResultSrcMem = 2'b01;
    localparam logic [1:0] ResultSrcPc4 = 2'b10;

    // funct3 load/store codes
    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    // Access size lives in funct3[1:0]; funct3[2] selects zero-extension
    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational load/store alignment: store byte-lane steering and replication,
// load byte/half extraction with sign or zero extension.
module riscv_lsu_align
    import riscv_memory_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] store_wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_ext;

    assign sign_ext = ~funct3_i[2];

    // Store steering: replicate data across lanes, enable only the addressed ones
    always_comb begin
        byte_en_o     = 4'b1111;
        store_wdata_o = store_data_i;
        case (funct3_i[1:0])
            SizeByte: begin
                byte_en_o     = 4'b0001 << addr_lo_i;
                store_wdata_o = {4{store_data_i[7:0]}};
            end
            SizeHalf: begin
                byte_en_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                store_wdata_o = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extract: pick the addressed byte/half, then extend to 32 bits
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = load_word_i[7:0];
            2'd1:    byte_sel = load_word_i[15:8];
            2'd2:    byte_sel = load_word_i[23:16];
            default: byte_sel = load_word_i[31:24];
        endcase
        half_sel    = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];
        load_data_o = load_word_i;
        case (funct3_i[1:0])
            SizeByte: load_data_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SizeHalf: load_data_o = {{16{sign_ext & half_sel[15]}}, half_sel};
            default:  ;
        endcase
    end

endmodule

// File: rtl/riscv_memory_stage.sv
// Memory stage: drives the data-memory req/ack bus, stalls the pipeline while an
// access is outstanding, and holds the MEM/WB pipeline register.
// Optional feature macro: RISCV_DMEM_TIMEOUT_EN adds a WAIT-cycle timeout and o_bus_err.
module riscv_memory_stage
    import riscv_memory_stage_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_reg_write_m,
    input  logic [1:0]      i_result_src_m,
    input  logic            i_mem_write_m,
    input  logic [2:0]      i_funct3_m,
    input  logic [XLEN-1:0] i_alu_result_m,
    input  logic [XLEN-1:0] i_write_data_m,
    input  logic [4:0]      i_rd_m,
    input  logic [XLEN-1:0] i_pc_plus_4m,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_ack,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_stall_m,
    output logic            o_misalign,
`ifdef RISCV_DMEM_TIMEOUT_EN
    output logic            o_bus_err,
`endif
    output logic            o_reg_write_w,
    output logic [1:0]      o_result_src_w,
    output logic [XLEN-1:0] o_alu_result_w,
    output logic [XLEN-1:0] o_read_data_w,
    output logic [4:0]      o_rd_w,
    output logic [XLEN-1:0] o_pc_plus_4w
);

    dmem_state_e     state_q;
    logic            mem_op;
    logic            misaligned;
    logic            access_ok;
    logic            timeout;
    logic            done;
    logic            bubble;
    logic [XLEN-1:0] load_data;

    assign mem_op = i_mem_write_m | (i_result_src_m == ResultSrcMem);

    // Half needs addr[0]=0, word needs addr[1:0]=0
    always_comb begin
        misaligned = 1'b0;
        case (i_funct3_m[1:0])
            SizeHalf: misaligned = i_alu_result_m[0];
            SizeWord: misaligned = |i_alu_result_m[1:0];
            default:  misaligned = 1'b0;
        endcase
    end

    assign access_ok = mem_op & ~misaligned;

`ifdef RISCV_DMEM_TIMEOUT_EN
    logic [7:0] wait_cnt_q;

    assign timeout   = (state_q == StWait) && !i_dmem_ack
                       && (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign o_bus_err = ~i_rst & timeout;

    // WAIT-cycle counter, restarted on every WAIT entry
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == StIdle) begin
            wait_cnt_q <= '0;
        end else if (!i_dmem_ack && !timeout) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end
`else
    logic unused_timeout_cycles;

    assign timeout               = 1'b0;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    // Reset gates the request off immediately, even mid-access
    always_comb begin
        o_dmem_req = 1'b0;
        if (!i_rst) begin
            o_dmem_req = (state_q == StIdle) ? access_ok : ~timeout;
        end
    end

    assign o_dmem_we   = i_mem_write_m;
    assign o_dmem_addr = {i_alu_result_m[XLEN-1:2], 2'b00};
    assign done        = o_dmem_req & i_dmem_ack;
    assign o_stall_m   = o_dmem_req & ~i_dmem_ack;
    assign o_misalign  = ~i_rst & (state_q == StIdle) & mem_op & misaligned;
    assign bubble      = o_stall_m | (mem_op & ~done);

    riscv_lsu_align u_lsu_align (
        .funct3_i      (i_funct3_m),
        .addr_lo_i     (i_alu_result_m[1:0]),
        .store_data_i  (i_write_data_m),
        .load_word_i   (i_dmem_rdata),
        .byte_en_o     (o_dmem_be),
        .store_wdata_o (o_dmem_wdata),
        .load_data_o   (load_data)
    );

    // Access FSM: leave IDLE only when a request goes unacknowledged
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle:  if (access_ok && !i_dmem_ack) state_q <= StWait;
                StWait:  if (i_dmem_ack || timeout) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // MEM/WB register: loads every cycle, bubble suppresses the register write
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_reg_write_w  <= 1'b0;
            o_result_src_w <= '0;
            o_alu_result_w <= '0;
            o_read_data_w  <= '0;
            o_rd_w         <= '0;
            o_pc_plus_4w   <= '0;
        end else begin
            o_reg_write_w  <= i_reg_write_m & ~bubble;
            o_result_src_w <= i_result_src_m;
            o_alu_result_w <= i_alu_result_m;
            o_read_data_w  <= load_data;
            o_rd_w         <= i_rd_m;
            o_pc_plus_4w   <= i_pc_plus_4m;
        end
    end

endmodule
